// File: rtl/mul_operand_prenorm.sv
// FP multiplier front-end: unpacks and classifies two operands, pre-normalizes
// subnormal significands and forms the biased product exponent over a 2-stage pipe.
module mul_operand_prenorm #(
  parameter int unsigned EXPO_W = 8,
  parameter int unsigned MANT_W = 23,
  parameter int unsigned LZC_W  = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXPO_W+MANT_W:0] opa,
  input  logic [EXPO_W+MANT_W:0] opb,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   sign_p,
  output logic [EXPO_W+1:0]      expo_a,
  output logic [EXPO_W+1:0]      expo_b,
  output logic [EXPO_W+1:0]      expo_p,
  output logic [MANT_W:0]        mant_a,
  output logic [MANT_W:0]        mant_b,
  output logic                   res_zero,
  output logic                   res_inf,
  output logic                   res_nan,
  output logic                   invalid
);

  localparam int unsigned OP_W  = EXPO_W + MANT_W + 1;
  localparam int unsigned XW    = EXPO_W + 2;
  localparam int unsigned MW    = MANT_W + 1;
  localparam int unsigned LZ1_W = LZC_W + 1;
  localparam logic [XW-1:0] BIAS = XW'((1 << (EXPO_W - 1)) - 1);

  // Leading zeros of a fraction; only meaningful for a nonzero fraction.
  function automatic logic [LZC_W-1:0] lzc(input logic [MANT_W-1:0] f);
    logic found;
    lzc   = '0;
    found = 1'b0;
    for (int i = int'(MANT_W) - 1; i >= 0; i--) begin
      if (!found && f[i]) begin
        lzc   = LZC_W'(int'(MANT_W) - 1 - i);
        found = 1'b1;
      end
    end
  endfunction

  logic [OP_W-1:0] op_in [2];
  assign op_in[0] = opa;
  assign op_in[1] = opb;

  // Stage 1 state
  logic                s1_valid_q, s1_valid_d;
  logic [1:0]          sgn_q, sgn_d;
  logic [1:0]          zero_q, zero_d;
  logic [1:0]          sub_q, sub_d;
  logic [1:0]          inf_q, inf_d;
  logic [1:0]          nan_q, nan_d;
  logic [1:0]          snan_q, snan_d;
  logic [EXPO_W-1:0]   exp_q [2];
  logic [EXPO_W-1:0]   exp_d [2];
  logic [MANT_W-1:0]   frac_q [2];
  logic [MANT_W-1:0]   frac_d [2];
  logic [LZC_W-1:0]    lz_q [2];
  logic [LZC_W-1:0]    lz_d [2];

  // Stage 2 state
  logic                s2_valid_q, s2_valid_d;
  logic                sign_p_q, sign_p_d;
  logic [MW-1:0]       mant_q [2];
  logic [MW-1:0]       mant_d [2];
  logic [XW-1:0]       expo_q [2];
  logic [XW-1:0]       expo_d [2];
  logic [XW-1:0]       expo_p_q, expo_p_d;
  logic                res_zero_q, res_zero_d;
  logic                res_inf_q, res_inf_d;
  logic                res_nan_q, res_nan_d;
  logic                invalid_q, invalid_d;

  logic s1_load, s2_load, inf_x_zero;

  // Stage 2 frees up on downstream accept; stage 1 frees up when stage 2 takes it.
  assign s2_load    = !s2_valid_q || out_ready;
  assign s1_load    = !s1_valid_q || s2_load;
  assign in_ready   = s1_load;
  assign inf_x_zero = (inf_q[0] && zero_q[1]) || (inf_q[1] && zero_q[0]);

  // Stage 1: unpack, classify, count leading zeros.
  always_comb begin
    s1_valid_d = s1_valid_q;
    sgn_d      = sgn_q;
    zero_d     = zero_q;
    sub_d      = sub_q;
    inf_d      = inf_q;
    nan_d      = nan_q;
    snan_d     = snan_q;
    exp_d      = exp_q;
    frac_d     = frac_q;
    lz_d       = lz_q;
    if (s1_load) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        for (int k = 0; k < 2; k++) begin
          sgn_d[k]  = op_in[k][OP_W-1];
          exp_d[k]  = op_in[k][OP_W-2 -: EXPO_W];
          frac_d[k] = op_in[k][MANT_W-1:0];
          zero_d[k] = (exp_d[k] == '0) && (frac_d[k] == '0);
          sub_d[k]  = (exp_d[k] == '0) && (frac_d[k] != '0);
          inf_d[k]  = (exp_d[k] == '1) && (frac_d[k] == '0);
          nan_d[k]  = (exp_d[k] == '1) && (frac_d[k] != '0);
          snan_d[k] = nan_d[k] && !frac_d[k][MANT_W-1];
          lz_d[k]   = lzc(frac_d[k]);
        end
      end
    end
  end

  // Stage 2: normalize significands, exponents, special-case flags.
  always_comb begin
    s2_valid_d = s2_valid_q;
    sign_p_d   = sign_p_q;
    mant_d     = mant_q;
    expo_d     = expo_q;
    expo_p_d   = expo_p_q;
    res_zero_d = res_zero_q;
    res_inf_d  = res_inf_q;
    res_nan_d  = res_nan_q;
    invalid_d  = invalid_q;
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        for (int k = 0; k < 2; k++) begin
          if (zero_q[k]) begin
            mant_d[k] = '0;
            expo_d[k] = '0;
          end else if (sub_q[k]) begin
            mant_d[k] = {1'b0, frac_q[k]} << (LZ1_W'(lz_q[k]) + LZ1_W'(1));
            expo_d[k] = -XW'(lz_q[k]);
          end else begin
            mant_d[k] = {1'b1, frac_q[k]};
            expo_d[k] = XW'(exp_q[k]);
          end
        end
        expo_p_d   = expo_d[0] + expo_d[1] - BIAS;
        sign_p_d   = sgn_q[0] ^ sgn_q[1];
        res_nan_d  = (|nan_q) || inf_x_zero;
        invalid_d  = (|snan_q) || inf_x_zero;
        res_inf_d  = (|inf_q) && !res_nan_d;
        res_zero_d = (|zero_q) && !res_nan_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      sgn_q      <= '0;
      zero_q     <= '0;
      sub_q      <= '0;
      inf_q      <= '0;
      nan_q      <= '0;
      snan_q     <= '0;
      exp_q      <= '{default: '0};
      frac_q     <= '{default: '0};
      lz_q       <= '{default: '0};
      s2_valid_q <= 1'b0;
      sign_p_q   <= 1'b0;
      mant_q     <= '{default: '0};
      expo_q     <= '{default: '0};
      expo_p_q   <= '0;
      res_zero_q <= 1'b0;
      res_inf_q  <= 1'b0;
      res_nan_q  <= 1'b0;
      invalid_q  <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      sgn_q      <= sgn_d;
      zero_q     <= zero_d;
      sub_q      <= sub_d;
      inf_q      <= inf_d;
      nan_q      <= nan_d;
      snan_q     <= snan_d;
      exp_q      <= exp_d;
      frac_q     <= frac_d;
      lz_q       <= lz_d;
      s2_valid_q <= s2_valid_d;
      sign_p_q   <= sign_p_d;
      mant_q     <= mant_d;
      expo_q     <= expo_d;
      expo_p_q   <= expo_p_d;
      res_zero_q <= res_zero_d;
      res_inf_q  <= res_inf_d;
      res_nan_q  <= res_nan_d;
      invalid_q  <= invalid_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign sign_p    = sign_p_q;
  assign mant_a    = mant_q[0];
  assign mant_b    = mant_q[1];
  assign expo_a    = expo_q[0];
  assign expo_b    = expo_q[1];
  assign expo_p    = expo_p_q;
  assign res_zero  = res_zero_q;
  assign res_inf   = res_inf_q;
  assign res_nan   = res_nan_q;
  assign invalid   = invalid_q;

endmodule

// File: tb/tb_mul_operand_prenorm.sv
// Scoreboard bench for mul_operand_prenorm: directed FP32 cases, backpressure,
// mid-operation reset and randomized traffic against an arithmetic reference model.
module tb_mul_operand_prenorm;

  typedef struct packed {
    logic        s;
    logic [9:0]  ea;
    logic [9:0]  eb;
    logic [9:0]  ep;
    logic [23:0] ma;
    logic [23:0] mb;
    logic        rz;
    logic        ri;
    logic        rn;
    logic        inv;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] opa, opb;
  logic        sign_p, res_zero, res_inf, res_nan, invalid;
  logic [9:0]  expo_a, expo_b, expo_p;
  logic [23:0] mant_a, mant_b;

  mul_operand_prenorm dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opa(opa), .opb(opb), .out_valid(out_valid), .out_ready(out_ready),
    .sign_p(sign_p), .expo_a(expo_a), .expo_b(expo_b), .expo_p(expo_p),
    .mant_a(mant_a), .mant_b(mant_b), .res_zero(res_zero), .res_inf(res_inf),
    .res_nan(res_nan), .invalid(invalid)
  );

  always #5 clk = ~clk;

  int   n_chk = 0, n_fail = 0, n_in = 0, n_out = 0, cyc = 0;
  bit   rand_mode = 0, check_lat = 0;
  exp_t cur_exp;
  exp_t sb_q [$];
  int   cyc_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t dut_vec();
    return {sign_p, expo_a, expo_b, expo_p, mant_a, mant_b, res_zero, res_inf, res_nan, invalid};
  endfunction

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: classify one FP32 operand and produce its normalized significand/exponent.
  function automatic void unpack_op(input logic [31:0] x, output logic [23:0] m, output int e,
                                    output bit z, output bit inf, output bit nan, output bit snan);
    int          ef, lz;
    int unsigned f;
    ef = int'(x[30:23]);
    f  = 32'(x[22:0]);
    z = 0; inf = 0; nan = 0; snan = 0;
    if (ef == 0 && f == 0) begin
      z = 1; m = 24'(0); e = 0;
    end else if (ef == 0) begin
      lz = 0;
      while (f < 32'h0040_0000) begin
        f = f * 2;
        lz++;
      end
      m = 24'(f * 2);
      e = -lz;
    end else if (ef == 255) begin
      m    = 24'(32'h0080_0000 + f);
      e    = 255;
      inf  = (f == 0);
      nan  = (f != 0);
      snan = nan && (f < 32'h0040_0000);
    end else begin
      m = 24'(32'h0080_0000 + f);
      e = ef;
    end
  endfunction

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t        r;
    logic [23:0] ma, mb;
    int          ea, eb;
    bit          za, ia, na, sa, zb, ib, nb, sb, bad;
    unpack_op(a, ma, ea, za, ia, na, sa);
    unpack_op(b, mb, eb, zb, ib, nb, sb);
    bad   = (ia && zb) || (ib && za);
    r.s   = a[31] ^ b[31];
    r.ea  = 10'(ea);
    r.eb  = 10'(eb);
    r.ep  = 10'(ea + eb - 127);
    r.ma  = ma;
    r.mb  = mb;
    r.rn  = na || nb || bad;
    r.inv = sa || sb || bad;
    r.ri  = (ia || ib) && !r.rn;
    r.rz  = (za || zb) && !r.rn;
    return r;
  endfunction

  function automatic logic [31:0] rand_op();
    logic [22:0] f;
    logic        s;
    s = 1'($urandom_range(0, 1));
    f = 23'($urandom);
    case ($urandom_range(0, 9))
      0: return {s, 31'(0)};
      1: begin
        f = f >> $urandom_range(0, 22);
        if (f == 0) f = 23'(1);
        return {s, 8'h00, f};
      end
      2: return {s, 8'hFF, 23'(0)};
      3: begin
        if (f == 0) f = 23'(1);
        return {s, 8'hFF, f};
      end
      default: return $urandom;
    endcase
  endfunction

  // Monitor: push on input transfer, compare/pop on output transfer, check hold while stalled.
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      cyc_q.delete();
      n_in  = 0;
      n_out = 0;
    end else begin
      if (in_valid && in_ready) begin
        sb_q.push_back(cur_exp);
        cyc_q.push_back(cyc);
        n_in++;
      end
      if (out_valid) begin
        n_chk++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_output: got %h with empty scoreboard", dut_vec());
        end else begin
          if (dut_vec() !== sb_q[0]) begin
            n_fail++;
            $display("FAIL %s op %0d: got %h expected %h",
                     out_ready ? "result" : "stall_hold", n_out, dut_vec(), sb_q[0]);
          end
          if (out_ready) begin
            if (check_lat) begin
              n_chk++;
              if (cyc - cyc_q[0] != 2) begin
                n_fail++;
                $display("FAIL latency op %0d: got %0d cycles expected 2", n_out, cyc - cyc_q[0]);
              end
            end
            void'(sb_q.pop_front());
            void'(cyc_q.pop_front());
            n_out++;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_mode) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input exp_t e);
    bit acc;
    int guard;
    opa = a; opb = b; cur_exp = e; in_valid = 1'b1;
    acc = 0; guard = 0;
    while (!acc) begin
      @(negedge clk);
      acc = in_ready;
      step();
      guard++;
      if (!acc && guard > 200) begin
        n_chk++; n_fail++;
        $display("FAIL accept_timeout: got in_ready=0 for %0d cycles expected accept", guard);
        acc = 1;
      end
    end
  endtask

  task automatic drain();
    int g = 0;
    while (sb_q.size() != 0 && g < 200) begin
      step();
      g++;
    end
    chk("drain_empty", 96'(sb_q.size()), 96'(0));
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_out_valid"}, 96'(out_valid), 96'(0));
    chk({tag, "_in_ready"}, 96'(in_ready), 96'(1));
    chk({tag, "_data"}, 96'(dut_vec()), 96'(0));
  endtask

  logic [31:0] bp_a [4];
  logic [31:0] bp_b [4];

  initial begin
    int k;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; opa = '0; opb = '0; cur_exp = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_reset_state("reset");
    step();

    // Directed cases with hand-derived expectations, back-to-back, no stalls.
    check_lat = 1;
    issue(32'h3FC00000, 32'h40000000, exp_t'{1'b0, 10'h07F, 10'h080, 10'h080, 24'hC00000, 24'h800000, 1'b0, 1'b0, 1'b0, 1'b0});
    issue(32'h00000001, 32'h3F800000, exp_t'{1'b0, 10'h3EA, 10'h07F, 10'h3EA, 24'h800000, 24'h800000, 1'b0, 1'b0, 1'b0, 1'b0});
    issue(32'h7F800000, 32'h80000000, exp_t'{1'b1, 10'h0FF, 10'h000, 10'h080, 24'h800000, 24'h000000, 1'b0, 1'b0, 1'b1, 1'b1});
    issue(32'h7FA00000, 32'h3F800000, exp_t'{1'b0, 10'h0FF, 10'h07F, 10'h0FF, 24'hA00000, 24'h800000, 1'b0, 1'b0, 1'b1, 1'b1});
    issue(32'h7FC00000, 32'h3F800000, exp_t'{1'b0, 10'h0FF, 10'h07F, 10'h0FF, 24'hC00000, 24'h800000, 1'b0, 1'b0, 1'b1, 1'b0});
    issue(32'h00000000, 32'h3F800000, exp_t'{1'b0, 10'h000, 10'h07F, 10'h000, 24'h000000, 24'h800000, 1'b1, 1'b0, 1'b0, 1'b0});
    issue(32'h007FFFFF, 32'h3F800000, exp_t'{1'b0, 10'h000, 10'h07F, 10'h000, 24'hFFFFFE, 24'h800000, 1'b0, 1'b0, 1'b0, 1'b0});
    issue(32'hFF800000, 32'h3F800000, exp_t'{1'b1, 10'h0FF, 10'h07F, 10'h0FF, 24'h800000, 24'h800000, 1'b0, 1'b1, 1'b0, 1'b0});
    in_valid = 1'b0;
    drain();
    check_lat = 0;

    // Backpressure: four back-to-back pairs against a 5-cycle stall.
    for (int i = 0; i < 4; i++) begin
      bp_a[i] = {1'($urandom_range(0, 1)), 8'($urandom_range(1, 254)), 23'($urandom)};
      bp_b[i] = {1'($urandom_range(0, 1)), 8'($urandom_range(1, 254)), 23'($urandom)};
    end
    out_ready = 1'b0;
    k = 0;
    opa = bp_a[0]; opb = bp_b[0]; cur_exp = model(bp_a[0], bp_b[0]); in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (in_ready) k++;
      @(posedge clk);
      #1;
      if (k < 4) begin
        opa = bp_a[k]; opb = bp_b[k]; cur_exp = model(bp_a[k], bp_b[k]);
      end
    end
    chk("bp_accepts", 96'(k), 96'(2));
    chk("bp_in_ready", 96'(in_ready), 96'(0));
    chk("bp_out_valid", 96'(out_valid), 96'(1));
    out_ready = 1'b1;
    for (int j = k; j < 4; j++) issue(bp_a[j], bp_b[j], model(bp_a[j], bp_b[j]));
    in_valid = 1'b0;
    drain();
    chk("bp_count", 96'(n_out), 96'(n_in));

    // Reset with both stages occupied: in-flight ops must vanish.
    out_ready = 1'b0;
    issue(32'h40400000, 32'h40800000, model(32'h40400000, 32'h40800000));
    issue(32'hC0A00000, 32'h00000010, model(32'hC0A00000, 32'h00000010));
    in_valid = 1'b0;
    chk("full_in_ready", 96'(in_ready), 96'(0));
    chk("full_out_valid", 96'(out_valid), 96'(1));
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk_reset_state("midrst");
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("midrst_no_emit", 96'(out_valid), 96'(0));
    end
    step();

    // Randomized traffic with bubbles and random backpressure.
    rand_mode = 1;
    for (int i = 0; i < 10000; i++) begin
      logic [31:0] a, b;
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        step();
      end
      a = rand_op();
      b = rand_op();
      issue(a, b, model(a, b));
    end
    in_valid = 1'b0;
    rand_mode = 0;
    out_ready = 1'b1;
    drain();
    chk("random_count", 96'(n_out), 96'(n_in));
    chk("random_n_in", 96'(n_in), 96'(10000));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_operand_prenorm.md
Name: mul_operand_prenorm

Overview:
- Front-end of the FP multiplier datapath. Accepts two packed IEEE operands, unpacks and classifies them, and pre-normalizes subnormal significands so each has an explicit leading 1.
- Computes the signed product exponent that the multiplier array and the post-multiply normalize/shift stage consume.
- 2-stage valid/ready pipeline: throughput 1 op/cycle, with full backpressure.

Parameters:
- EXPO_W, 8: exponent field width.
- MANT_W, 23: fraction field width, hidden bit excluded.
- LZC_W, 5: leading-zero-count width; must satisfy 2^LZC_W >= MANT_W.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept an operand pair this cycle.
- opa  in  EXPO_W+MANT_W+1  packed operand A: {sign, exp, frac}.
- opb  in  EXPO_W+MANT_W+1  packed operand B.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- sign_p  out  1  product sign, sa^sb.
- expo_a, expo_b  out  EXPO_W+2  per-operand unbiased-offset exponent, two's complement.
- expo_p  out  EXPO_W+2  product exponent expo_a+expo_b-BIAS, two's complement; MSB set means negative.
- mant_a, mant_b  out  MANT_W+1  normalized significands; MSB is 1 unless the operand is zero.
- res_zero, res_inf, res_nan, invalid  out  1 each  special-case flags.

Behaviour:
- BIAS = 2^(EXPO_W-1)-1. Classification per operand:
  - zero: E=0, F=0.
  - subnormal: E=0, F!=0.
  - normal: 0<E<all-ones.
  - inf: E=all-ones, F=0.
  - nan: E=all-ones, F!=0. snan when F MSB=0.
- Normal operand: mant={1,F}, expo=E, zero-extended to EXPO_W+2 bits.
- Subnormal operand: lz = leading zeros of F, range 0..MANT_W-1.
  - mant = {0,F} << (lz+1), so the MSB is 1.
  - expo = -lz, two's complement.
- Zero operand: mant=0, expo=0.
- Inf/NaN operand: mant={1,F}, expo=E; these values are don't-care downstream because the flags dominate.
- expo_p = expo_a + expo_b - BIAS, computed in EXPO_W+2 bits. No overflow is possible: FP32 range is -171..381.
- Flags:
  - res_nan = any nan | (inf & zero).
  - invalid = any snan | (inf & zero).
  - res_inf = any inf & !res_nan.
  - res_zero = any zero & !res_nan.
- Stage 1 registers: unpacked fields, class bits, lz per operand.
- Stage 2 registers: shifted significands, expo_a/expo_b/expo_p, flags, sign_p.
- Handshake:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
  - Stage 2 loads when it is empty or out_ready=1.
  - Stage 1 loads when it is empty or stage 2 loads.
  - in_ready = !s1_valid | s2_load. It is combinational from out_ready; no combinational path from in_valid to in_ready.
- Latency: a pair accepted at edge N appears with out_valid=1 after edge N+2 when there is no stall.
- Stall: while out_valid & !out_ready, all outputs hold stable. Stage 1 still fills if empty. in_ready=0 once both stages are full.
- No op is dropped or duplicated; order is preserved.
- Bubbles: in_valid=0 with s1 advancing clears s1_valid. out_valid tracks s2_valid exactly.
- Reset:
  - s1_valid=s2_valid=0 and out_valid=0.
  - All data outputs are 0 and all flags are 0.
  - in_ready=1 in the cycle after reset.
  - Reset asserted mid-operation discards in-flight ops; nothing is emitted afterward.
  - rst has priority over any transfer in the same cycle.
- Simultaneous accept and emit on a full pipe: both transfers occur; the pipe stays full.

Test Plan:
- Normal: opa=0x3FC00000 (1.5), opb=0x40000000 (2.0), out_ready=1 -> 2 cycles later out_valid=1, mant_a=0xC00000, mant_b=0x800000, expo_a=127, expo_b=128, expo_p=128, sign_p=0, all flags 0.
- Subnormal: opa=0x00000001, opb=0x3F800000 -> lz=22, mant_a=0x800000, expo_a=10'h3EA (-22), expo_b=127, expo_p=10'h3EA, res_zero=0.
- Specials:
  - 0x7F800000 * 0x80000000 -> res_nan=1, invalid=1, sign_p=1.
  - 0x7FA00000 * 0x3F800000 -> res_nan=1, invalid=1.
  - 0x7FC00000 * 0x3F800000 -> res_nan=1, invalid=0.
  - 0x00000000 * 0x3F800000 -> res_zero=1.
- Backpressure: issue 4 back-to-back pairs with out_ready=0 for 5 cycles -> in_ready=0 after 2 accepts, outputs frozen on pair 0. Release out_ready -> pairs 0..3 emerge in order, one per cycle, with no loss.
- Reset mid-op: both stages valid, assert rst one cycle -> next cycle out_valid=0, all outputs 0, in_ready=1. Prior ops are never emitted.
- Random: 10k random FP32 pairs, including subnormals, with random in_valid/out_ready -> every field matches the reference model, and the output count equals the input count.
